// File: rtl/processor_pkg.sv
// Shared decode-stage definitions: forwarding select codes and the hazard slot record
// that tracks an in-flight register write.
package processor_pkg;

    localparam int REG_IDX_W = 3;

    localparam logic [1:0] FWD_BANK   = 2'b00;
    localparam logic [1:0] FWD_EXMEM  = 2'b01;
    localparam logic [1:0] FWD_MEMWB  = 2'b10;
    localparam logic [1:0] FWD_WBHOLD = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dest;
        logic                 writes;
        logic                 is_load;
    } hz_slot_t;

endpackage

// File: rtl/id_forward_select.sv
// Per-operand hazard lookup: picks the youngest in-flight producer of one source register
// and flags a producer that is a load still sitting in EX.
module id_forward_select
    import processor_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx_i,
    input  logic                 uses_i,
    input  hz_slot_t             slot_ex_i,
    input  hz_slot_t             slot_mem_i,
    input  hz_slot_t             slot_wb_i,
    output logic                 match_ex_load_o,
    output logic [1:0]           fwd_sel_o
);

    function automatic logic slot_hit(input hz_slot_t s, input logic [REG_IDX_W-1:0] idx,
                                      input logic uses);
        return s.valid && s.writes && (s.dest == idx) && uses;
    endfunction

    logic hit_ex, hit_mem, hit_wb;

    assign hit_ex  = slot_hit(slot_ex_i,  idx_i, uses_i);
    assign hit_mem = slot_hit(slot_mem_i, idx_i, uses_i);
    assign hit_wb  = slot_hit(slot_wb_i,  idx_i, uses_i);

    assign match_ex_load_o = hit_ex && slot_ex_i.is_load;

    // Youngest producer wins so the consumer never sees a stale value.
    always_comb begin
        fwd_sel_o = FWD_BANK;
        if (hit_ex)       fwd_sel_o = FWD_EXMEM;
        else if (hit_mem) fwd_sel_o = FWD_MEMWB;
        else if (hit_wb)  fwd_sel_o = FWD_WBHOLD;
    end

endmodule

// File: rtl/id_hazard_control.sv
// ID-stage hazard controller: tracks pending writes in EX/MEM/WB, raises the load-use
// stall, qualifies issue and registers the EX operand forwarding selects.
module id_hazard_control
    import processor_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   id_valid,
    input  logic [REG_IDX_W-1:0]   id_rs,
    input  logic [REG_IDX_W-1:0]   id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [REG_IDX_W-1:0]   id_dest,
    input  logic                   id_writes,
    input  logic                   id_is_load,
    input  logic                   flush,
    input  logic                   freeze,
    output logic                   stall,
    output logic                   issue,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_count
);

    hz_slot_t               ex_q, mem_q, wb_q;
    hz_slot_t               ex_d, mem_d, wb_d;
    logic [1:0]             fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   ld_a, ld_b;
    logic [1:0]             sel_a, sel_b;

    id_forward_select u_sel_rs (
        .idx_i           (id_rs),
        .uses_i          (id_uses_rs),
        .slot_ex_i       (ex_q),
        .slot_mem_i      (mem_q),
        .slot_wb_i       (wb_q),
        .match_ex_load_o (ld_a),
        .fwd_sel_o       (sel_a)
    );

    id_forward_select u_sel_rt (
        .idx_i           (id_rt),
        .uses_i          (id_uses_rt),
        .slot_ex_i       (ex_q),
        .slot_mem_i      (mem_q),
        .slot_wb_i       (wb_q),
        .match_ex_load_o (ld_b),
        .fwd_sel_o       (sel_b)
    );

    // Flush overrides the stall: the instruction is discarded rather than held.
    assign stall = id_valid && !flush && (ld_a || ld_b);
    assign issue = id_valid && !stall && !flush && !freeze;

    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            wb_d    = mem_q;
            mem_d   = flush ? '0 : ex_q;
            ex_d    = '0;
            fwd_a_d = FWD_BANK;
            fwd_b_d = FWD_BANK;
            if (issue) begin
                ex_d.valid   = 1'b1;
                ex_d.dest    = id_dest;
                ex_d.writes  = id_writes;
                ex_d.is_load = id_is_load;
                fwd_a_d      = sel_a;
                fwd_b_d      = sel_b;
            end
            if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_BANK;
            fwd_b_q <= FWD_BANK;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_hazard_control.sv
// Directed-vector bench for id_hazard_control; a 2-bit stall counter makes saturation reachable.
module tb_id_hazard_control;

    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [2:0]    id_rs = '0, id_rt = '0, id_dest = '0;
    logic          id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_writes = 1'b0, id_is_load = 1'b0;
    logic          flush = 1'b0, freeze = 1'b0;
    logic          stall, issue;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    id_hazard_control #(.STALL_CNT_W(CW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_dest     (id_dest),
        .id_writes   (id_writes),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .freeze      (freeze),
        .stall       (stall),
        .issue       (issue),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_count (stall_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drv(input logic v, input logic [2:0] rs, input logic urs,
                       input logic [2:0] rt, input logic urt,
                       input logic [2:0] dst, input logic wr, input logic ld);
        id_valid   = v;
        id_rs      = rs;
        id_uses_rs = urs;
        id_rt      = rt;
        id_uses_rt = urt;
        id_dest    = dst;
        id_writes  = wr;
        id_is_load = ld;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_fwd_a", 16'(fwd_a), 16'h0);
        chk("rst_fwd_b", 16'(fwd_b), 16'h0);
        chk("rst_cnt", 16'(stall_count), 16'h0);
        chk("rst_stall", 16'(stall), 16'h0);
        chk("rst_issue", 16'(issue), 16'h0);
        reset_n = 1'b1;
        step();

        // ALU r3 then reader of r3
        drv(1, 1, 1, 2, 1, 3, 1, 0);
        chk("alu_issue", 16'(issue), 16'h1);
        step();
        drv(1, 3, 1, 6, 1, 7, 1, 0);
        chk("alu_nostall", 16'(stall), 16'h0);
        chk("alu_cons_issue", 16'(issue), 16'h1);
        step();
        chk("alu_fwd_a", 16'(fwd_a), 16'h1);
        chk("alu_fwd_b", 16'(fwd_b), 16'h0);
        drain();

        // load r5 then reader of r5 via rt
        drv(1, 1, 1, 0, 0, 5, 1, 1);
        chk("ld_issue", 16'(issue), 16'h1);
        step();
        drv(1, 0, 0, 5, 1, 6, 1, 0);
        chk("lu_stall", 16'(stall), 16'h1);
        chk("lu_noissue", 16'(issue), 16'h0);
        step();
        chk("lu_cnt", 16'(stall_count), 16'h1);
        chk("lu_stall_gone", 16'(stall), 16'h0);
        chk("lu_issue", 16'(issue), 16'h1);
        step();
        chk("lu_fwd_b", 16'(fwd_b), 16'h2);
        chk("lu_fwd_a", 16'(fwd_a), 16'h0);
        chk("lu_cnt_hold", 16'(stall_count), 16'h1);
        drain();

        // producer r2, two independents, reader at distance 3 and 4
        drv(1, 0, 0, 0, 0, 2, 1, 0);
        step();
        drv(1, 0, 0, 0, 0, 1, 1, 0);
        step();
        step();
        drv(1, 2, 1, 0, 0, 3, 1, 0);
        chk("d3_nostall", 16'(stall), 16'h0);
        step();
        chk("d3_fwd_a", 16'(fwd_a), 16'h3);
        drv(1, 2, 1, 0, 0, 4, 1, 0);
        step();
        chk("d4_fwd_a", 16'(fwd_a), 16'h0);
        drain();

        // r4 in WB and EX: youngest wins; r0 is an ordinary register
        drv(1, 0, 0, 0, 0, 4, 1, 0);
        step();
        drv(1, 0, 0, 0, 0, 1, 1, 0);
        step();
        drv(1, 0, 0, 0, 0, 4, 1, 0);
        step();
        drv(1, 4, 1, 4, 1, 5, 1, 0);
        step();
        chk("yw_fwd_a", 16'(fwd_a), 16'h1);
        chk("yw_fwd_b", 16'(fwd_b), 16'h1);
        drv(1, 0, 0, 0, 0, 0, 1, 0);
        step();
        drv(1, 0, 1, 0, 0, 6, 1, 0);
        step();
        chk("r0_fwd_a", 16'(fwd_a), 16'h1);
        drv(1, 0, 1, 0, 0, 7, 1, 0);
        step();
        chk("r0_mem_fwd_a", 16'(fwd_a), 16'h2);
        drain();

        // flush during load-use stall
        drv(1, 0, 0, 0, 0, 5, 1, 1);
        step();
        flush = 1'b1;
        drv(1, 0, 0, 5, 1, 6, 1, 0);
        chk("fl_stall", 16'(stall), 16'h0);
        chk("fl_issue", 16'(issue), 16'h0);
        step();
        flush = 1'b0;
        drv(1, 0, 0, 5, 1, 6, 1, 0);
        chk("fl_fwd_b", 16'(fwd_b), 16'h0);
        chk("fl_cnt", 16'(stall_count), 16'h1);
        chk("fl_no_restall", 16'(stall), 16'h0);
        chk("fl_reissue", 16'(issue), 16'h1);
        step();
        chk("fl_load_gone", 16'(fwd_b), 16'h0);
        drain();

        // freeze for three cycles while a load-use stall is pending
        drv(1, 0, 0, 0, 0, 1, 1, 0);
        step();
        drv(1, 1, 1, 0, 0, 5, 1, 1);
        step();
        chk("fz_pre_fwd_a", 16'(fwd_a), 16'h1);
        freeze = 1'b1;
        drv(1, 0, 0, 5, 1, 6, 1, 0);
        chk("fz_stall", 16'(stall), 16'h1);
        chk("fz_issue", 16'(issue), 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fz_hold_fwd_a", 16'(fwd_a), 16'h1);
            chk("fz_hold_cnt", 16'(stall_count), 16'h1);
            chk("fz_hold_stall", 16'(stall), 16'h1);
        end
        freeze = 1'b0;
        #1;
        chk("fz_rel_stall", 16'(stall), 16'h1);
        step();
        chk("fz_rel_cnt", 16'(stall_count), 16'h2);
        chk("fz_rel_bubble", 16'(fwd_a), 16'h0);
        chk("fz_rel_issue", 16'(issue), 16'h1);
        step();
        chk("fz_rel_fwd_b", 16'(fwd_b), 16'h2);
        drain();

        // asynchronous reset in the middle of a cycle
        drv(1, 0, 0, 0, 0, 3, 1, 0);
        step();
        drv(1, 3, 1, 0, 0, 4, 1, 1);
        step();
        chk("ar_pre_fwd_a", 16'(fwd_a), 16'h1);
        drv(1, 4, 1, 0, 0, 5, 1, 0);
        chk("ar_pre_stall", 16'(stall), 16'h1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_stall", 16'(stall), 16'h0);
        chk("ar_issue", 16'(issue), 16'h1);
        chk("ar_fwd_a", 16'(fwd_a), 16'h0);
        chk("ar_cnt", 16'(stall_count), 16'h0);
        #1;
        reset_n = 1'b1;
        drain();

        // counter saturates at all-ones
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 0, 0, 0, 5, 1, 1);
            step();
            drv(1, 0, 0, 5, 1, 6, 1, 0);
            step();
            chk("sat_cnt", 16'(stall_count), (i < 3) ? 16'(i + 1) : 16'h3);
            step();
        end
        drain();
        chk("sat_final", 16'(stall_count), 16'h3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
